// File: rtl/plab2_pic_pkg.sv
// Shared types for the multicore PIC: FSM state encoding and pointer-width helper.
package plab2_pic_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETPRIO = 3'd1,
    S_ARB     = 3'd2,
    S_ACK     = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  // Width of a core index; never less than one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plab2_pic_rr_arbiter.sv
// Combinational rotating-priority picker: first set req bit at or after start, modulo NUM_CORES.
module plab2_pic_rr_arbiter
  import plab2_pic_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int PTR_W     = ptr_w(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [PTR_W-1:0]     start,
  output logic [PTR_W-1:0]     winner,
  output logic                 valid
);

  logic [PTR_W:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      // start + i stays below 2*NUM_CORES, so one conditional subtract is the modulo
      idx = {1'b0, start} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_CORES)) idx = idx - (PTR_W+1)'(NUM_CORES);
      if (!valid && req[idx[PTR_W-1:0]]) begin
        valid  = 1'b1;
        winner = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/plab2_proc_pic_multi.sv
// Multicore programmable interrupt controller: programmable-priority arbitration, ack/val pulses, hold-off.
// Optional rotating fairness after each grant when PLAB2_PIC_ROUNDROBIN_EN is defined.
module plab2_proc_pic_multi
  import plab2_pic_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int HOLDOFF   = 2,
  parameter int PTR_W     = ptr_w(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] intr_rq,
  input  logic [NUM_CORES-1:0] intr_set,
  output logic [NUM_CORES-1:0] intr_ack,
  output logic [NUM_CORES-1:0] intr_val,
  output logic [PTR_W-1:0]     prio_ptr
);

  localparam int CNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [NUM_CORES-1:0] ONE = {{(NUM_CORES-1){1'b0}}, 1'b1};

  state_t             state;
  logic [PTR_W-1:0]   grant;
  logic [CNT_W-1:0]   cnt;

  logic [PTR_W-1:0]   winner;
  logic               win_vld;
  logic [PTR_W-1:0]   set_idx;
  logic               set_any;
  logic [PTR_W-1:0]   grant_nxt;

  plab2_pic_rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .PTR_W     (PTR_W)
  ) u_arb (
    .req    (intr_rq),
    .start  (prio_ptr),
    .winner (winner),
    .valid  (win_vld)
  );

  // Lowest-index intr_set bit wins re-prioritisation.
  always_comb begin
    set_any = |intr_set;
    set_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--)
      if (intr_set[i]) set_idx = PTR_W'(i);
  end

  assign grant_nxt = (grant == PTR_W'(NUM_CORES - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      prio_ptr <= '0;
      grant    <= '0;
      cnt      <= '0;
      intr_ack <= '0;
      intr_val <= '0;
    end else begin
      intr_ack <= '0;
      intr_val <= '0;
      case (state)
        S_IDLE: state <= S_SETPRIO;
        S_SETPRIO: begin
          if (set_any) begin
            prio_ptr <= set_idx;
            state    <= S_ARB;
          end
        end
        S_ARB: begin
          if (set_any) prio_ptr <= set_idx;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (win_vld) begin
            // Arbitration sees the pre-set pointer; the grant is latched here.
            grant    <= winner;
            intr_ack <= ONE << winner;
            state    <= S_ACK;
          end
        end
        S_ACK: begin
          if (set_any) prio_ptr <= set_idx;
          intr_val <= ONE << grant;
          state    <= S_RESP;
        end
        S_RESP: begin
`ifdef PLAB2_PIC_ROUNDROBIN_EN
          prio_ptr <= set_any ? set_idx : grant_nxt;
`else
          if (set_any) prio_ptr <= set_idx;
`endif
          cnt   <= CNT_W'(HOLDOFF);
          state <= S_ARB;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef PLAB2_PIC_ROUNDROBIN_EN
  logic unused_grant_nxt;
  assign unused_grant_nxt = ^grant_nxt;
`endif

endmodule

// File: tb/tb_plab2_proc_pic_multi.sv
// Directed self-checking bench for plab2_proc_pic_multi (NUM_CORES=4, HOLDOFF=2).
module tb_plab2_proc_pic_multi;
  import plab2_pic_pkg::*;

  localparam int N  = 4;
  localparam int HO = 2;

  logic       clk;
  logic       reset;
  logic [3:0] intr_rq, intr_set, intr_ack, intr_val;
  logic [1:0] prio_ptr;

  int         nchk = 0;
  int         nerr = 0;
  logic [1:0] eptr;

  plab2_proc_pic_multi #(
    .NUM_CORES (N),
    .HOLDOFF   (HO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .intr_rq  (intr_rq),
    .intr_set (intr_set),
    .intr_ack (intr_ack),
    .intr_val (intr_val),
    .prio_ptr (prio_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ea, input logic [3:0] ev,
                         input logic [1:0] ep);
    chk({tag, "_ack"}, 32'(intr_ack), 32'(ea));
    chk({tag, "_val"}, 32'(intr_val), 32'(ev));
    chk({tag, "_ptr"}, 32'(prio_ptr), 32'(ep));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [3:0] oh(input int g);
    logic [3:0] one;
    one = 4'b0001;
    return one << g;
  endfunction

  // One grant with requests already pending and hold-off expired: ack, val, then HO+1 quiet cycles.
  task automatic grant(input string tag, input int g);
    cyc(); chk_out({tag, "_a"}, oh(g), 4'b0, eptr);
    cyc(); chk_out({tag, "_v"}, 4'b0, oh(g), eptr);
`ifdef PLAB2_PIC_ROUNDROBIN_EN
    eptr = 2'((g + 1) % N);
`endif
    for (int i = 0; i < HO + 1; i++) begin
      cyc(); chk_out({tag, "_q"}, 4'b0, 4'b0, eptr);
    end
  endtask

  initial begin
    reset    = 1'b1;
    intr_rq  = '0;
    intr_set = '0;
    eptr     = '0;
    repeat (2) cyc();
    chk_out("reset", 4'b0, 4'b0, 2'd0);
    chk("reset_state", 32'(dut.state), 32'(S_IDLE));
    reset = 1'b0;
    cyc();
    chk("setprio_state", 32'(dut.state), 32'(S_SETPRIO));

    // Requests before any priority programming are ignored.
    intr_rq = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk_out("noset", 4'b0, 4'b0, 2'd0);
      chk("noset_state", 32'(dut.state), 32'(S_SETPRIO));
    end

    intr_rq  = '0;
    intr_set = 4'b0100;
    cyc();
    eptr = 2'd2;
    chk_out("prog", 4'b0, 4'b0, eptr);
    chk("prog_state", 32'(dut.state), 32'(S_ARB));
    intr_set = '0;
    intr_rq  = 4'b1111;

`ifdef PLAB2_PIC_ROUNDROBIN_EN
    grant("g0", 2); grant("g1", 3); grant("g2", 0); grant("g3", 1);
`else
    grant("g0", 2); grant("g1", 2); grant("g2", 2); grant("g3", 2);
`endif
    intr_rq = '0;

    // Wrap-around search from pointer 3.
    intr_set = 4'b1000;
    cyc();
    eptr = 2'd3;
    chk_out("wrapset", 4'b0, 4'b0, eptr);
    intr_set = '0;
    intr_rq  = 4'b0011;
    grant("wrap", 0);

    // Request present only for the arbitration cycle.
    intr_rq = 4'b0010;
    cyc(); chk_out("pulse_a", 4'b0010, 4'b0, eptr);
    intr_rq = '0;
    cyc(); chk_out("pulse_v", 4'b0, 4'b0010, eptr);
`ifdef PLAB2_PIC_ROUNDROBIN_EN
    eptr = 2'd2;
`endif
    for (int i = 0; i < 6; i++) begin
      cyc(); chk_out("pulse_q", 4'b0, 4'b0, eptr);
    end

    // Set and request in the same arbitration cycle: old pointer arbitrates.
    intr_set = 4'b0100;
    cyc();
    eptr = 2'd2;
    chk_out("same_pre", 4'b0, 4'b0, eptr);
    intr_set = 4'b0001;
    intr_rq  = 4'b0110;
    cyc();
    eptr = 2'd0;
    chk_out("same_a", 4'b0100, 4'b0, eptr);
    intr_set = '0;
    intr_rq  = '0;
    cyc(); chk_out("same_v", 4'b0, 4'b0100, eptr);
`ifdef PLAB2_PIC_ROUNDROBIN_EN
    eptr = 2'd3;
`endif
    for (int i = 0; i < 3; i++) begin
      cyc(); chk_out("same_q", 4'b0, 4'b0, eptr);
    end

    // Reset during S_ACK kills the pulse at once; nothing until re-programmed.
    intr_rq = 4'b0001;
    cyc(); chk_out("rst_a", 4'b0001, 4'b0, eptr);
    #2 reset = 1'b1;
    #1;
    eptr = 2'd0;
    chk_out("rst_async", 4'b0, 4'b0, eptr);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(); chk_out("rst_idle", 4'b0, 4'b0, eptr);
    end
    intr_set = 4'b0010;
    cyc();
    eptr = 2'd1;
    chk_out("reprog", 4'b0, 4'b0, eptr);
    intr_set = '0;
    grant("regrant", 0);
    intr_rq = '0;
    cyc();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
